// File: rtl/hazard_ctl.sv
// -----------------------------------------------------------------------------
// hazard_ctl
//
// Pipeline interlock controller for a five-stage in-order core. It tracks the
// instructions sitting in stages 3, 4 and 5, detects read-after-write hazards
// against the instruction in stage 2, selects Z5 forwarding into the stage-3
// operand registers, squashes wrong-path fetches after a taken branch, and
// drains the pipeline before stopping on a hlt instruction.
//
// Build option:
//   VESPA_FWD_EN  - when defined, a producer sitting in stage 5 is forwarded
//                   (c5a/c6a/c7). When undefined, forwarding selects are tied
//                   low and a stage-5 producer stalls stage 2 like stage 3/4.
//
// Parameters:
//   RW         register-address width
//   BR_SQUASH  wrong-path cycles squashed after a taken branch (1..3)
//
// Ports:
//   clk        rising-edge clock
//   clr        asynchronous active-low reset; forces every output low
//   a1, a2     stage-2 source registers (X operand, Y operand / store data)
//   use1, use2 stage-2 instruction reads a1 / reads a2 into Y3
//   st2        stage-2 instruction is a store (a2 is store data)
//   wr2, ld2   stage-2 instruction writes a register / is a load
//   dst2       stage-2 destination register
//   cond2      stage-2 branch is taken
//   hlt2       stage-2 hlt decoded
//   mem_wait   memory stage not ready
//   pause3     hold stage-3 registers
//   nop3       load a NOP into IR3
//   stall2     hold IR2 / PC2
//   flush      kill the instruction being fetched
//   c5a, c6a   X3 / Y3 take Z5
//   c7         MD3 takes Z5
//   halted     processor stopped
// -----------------------------------------------------------------------------
module hazard_ctl #(
    parameter int unsigned RW        = 5,
    parameter int unsigned BR_SQUASH = 2
) (
    input  logic          clk,
    input  logic          clr,
    input  logic [RW-1:0] a1,
    input  logic [RW-1:0] a2,
    input  logic          use1,
    input  logic          use2,
    input  logic          st2,
    input  logic          wr2,
    input  logic          ld2,
    input  logic [RW-1:0] dst2,
    input  logic          cond2,
    input  logic          hlt2,
    input  logic          mem_wait,
    output logic          pause3,
    output logic          nop3,
    output logic          stall2,
    output logic          flush,
    output logic          c5a,
    output logic          c6a,
    output logic          c7,
    output logic          halted
);

    // -------------------------------------------------------------------------
    // Types and state
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic          valid;
        logic          wr;
        logic          ld;
        logic [RW-1:0] dst;
    } trk_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } state_t;

    localparam trk_t       TRK_EMPTY   = '0;
    localparam logic [1:0] SQUASH_LOAD = 2'(BR_SQUASH);

    state_t     state_q, state_d;
    trk_t       s3_q, s3_d;
    trk_t       s4_q, s4_d;
    trk_t       s5_q, s5_d;
    logic [1:0] cnt_q, cnt_d;

    // Entry in stage 3/4/5 is a live producer of register `a`.
    function automatic logic produces(input trk_t e, input logic [RW-1:0] a);
        return e.valid & e.wr & (e.dst == a);
    endfunction

    // -------------------------------------------------------------------------
    // Operand dependency decode
    // -------------------------------------------------------------------------
    logic m3_a1, m4_a1, m5_a1;
    logic m3_a2, m4_a2, m5_a2;
    logic need1, need2;
    logic dep_34;
    logic dep;

    always_comb begin
        m3_a1  = produces(s3_q, a1);
        m4_a1  = produces(s4_q, a1);
        m5_a1  = produces(s5_q, a1);
        m3_a2  = produces(s3_q, a2);
        m4_a2  = produces(s4_q, a2);
        m5_a2  = produces(s5_q, a2);
        need1  = use1;
        need2  = use2 | st2;
        dep_34 = (need1 & (m3_a1 | m4_a1)) | (need2 & (m3_a2 | m4_a2));
`ifdef VESPA_FWD_EN
        dep    = dep_34;
`else
        dep    = dep_34 | (need1 & m5_a1) | (need2 & m5_a2);
`endif
    end

    // -------------------------------------------------------------------------
    // Control decode and outputs
    // -------------------------------------------------------------------------
    logic run;
    logic pause;
    logic squash;
    logic hazard;
    logic issue_ok;
    logic br_take;
    logic hlt_take;
    logic fwd_ok;
    logic nop3_c;
    logic stall2_c;
    logic c5a_c, c6a_c, c7_c;

    always_comb begin
        run      = (state_q == RUN);
        pause    = mem_wait;
        squash   = (cnt_q != '0);
        // Wrong-path instructions during a squash are discarded anyway, so
        // they never raise an interlock.
        hazard   = run & ~squash & dep;
        // Branch and hlt act only when the instruction actually leaves stage
        // 2; a hazard therefore defers the branch until it re-issues.
        issue_ok = run & ~pause & ~squash & ~hazard;
        br_take  = issue_ok & cond2;
        hlt_take = issue_ok & hlt2 & ~cond2;

        stall2_c = pause | hazard | ~run;
        // hlt itself produces nothing, so it enters the tracker as a bubble;
        // the drain then only waits for the instructions ahead of it.
        nop3_c   = ~pause & (hazard | squash | hlt_take | ~run);

        fwd_ok   = run & ~squash & ~hazard;
`ifdef VESPA_FWD_EN
        c5a_c    = fwd_ok & use1 & m5_a1;
        c6a_c    = fwd_ok & use2 & m5_a2;
        c7_c     = fwd_ok & st2  & m5_a2;
`else
        c5a_c    = 1'b0;
        c6a_c    = 1'b0;
        c7_c     = 1'b0;
`endif
    end

    // Reset drives every output low immediately, including those that are
    // purely combinational from the inputs.
    always_comb begin
        pause3 = clr & pause;
        nop3   = clr & nop3_c;
        stall2 = clr & stall2_c;
        flush  = clr & squash;
        c5a    = clr & c5a_c;
        c6a    = clr & c6a_c;
        c7     = clr & c7_c;
        halted = clr & (state_q == HALT);
    end

    // -------------------------------------------------------------------------
    // Next-state: tracker shift, squash counter, run/drain/halt FSM
    // -------------------------------------------------------------------------
    always_comb begin
        s3_d    = s3_q;
        s4_d    = s4_q;
        s5_d    = s5_q;
        cnt_d   = cnt_q;
        state_d = state_q;

        if (!pause) begin
            s5_d = s4_q;
            s4_d = s3_q;
            if (nop3_c) begin
                s3_d = TRK_EMPTY;
            end else begin
                s3_d.valid = 1'b1;
                s3_d.wr    = wr2;
                s3_d.ld    = ld2;
                s3_d.dst   = dst2;
            end

            if (br_take) begin
                cnt_d = SQUASH_LOAD;
            end else if (squash) begin
                cnt_d = cnt_q - 2'd1;
            end

            case (state_q)
                RUN: begin
                    if (hlt_take) begin
                        state_d = DRAIN;
                    end
                end
                DRAIN: begin
                    if (!s3_q.valid && !s4_q.valid && !s5_q.valid) begin
                        state_d = HALT;
                    end
                end
                HALT: begin
                    state_d = HALT;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= RUN;
            s3_q    <= TRK_EMPTY;
            s4_q    <= TRK_EMPTY;
            s5_q    <= TRK_EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s3_q    <= s3_d;
            s4_q    <= s4_d;
            s5_q    <= s5_d;
            cnt_q   <= cnt_d;
        end
    end

    // The load tag of the retiring stage-5 entry has no consumer here.
    logic unused_s5_ld;
    assign unused_s5_ld = s5_q.ld;

endmodule

// File: tb/tb_hazard_ctl.sv
module tb_hazard_ctl;

    localparam int unsigned RW = 5;

`ifdef VESPA_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clk;
    logic          clr;
    logic [RW-1:0] a1, a2, dst2;
    logic          use1, use2, st2, wr2, ld2, cond2, hlt2, mem_wait;
    logic          pause3, nop3, stall2, flush, c5a, c6a, c7, halted;

    // {pause3, nop3, stall2, flush, c5a, c6a, c7, halted}
    logic [7:0] outs;
    assign outs = {pause3, nop3, stall2, flush, c5a, c6a, c7, halted};

    localparam logic [7:0] E_IDLE   = 8'b0000_0000;
    localparam logic [7:0] E_HAZ    = 8'b0110_0000;
    localparam logic [7:0] E_FLUSH  = 8'b0101_0000;
    localparam logic [7:0] E_PAUSE  = 8'b1010_0000;
    localparam logic [7:0] E_PFLUSH = 8'b1011_0000;
    localparam logic [7:0] E_HALT   = 8'b0110_0001;
    localparam logic [7:0] E_C5A    = 8'b0000_1000;

    int checks = 0;
    int errors = 0;
    int nstall;

    hazard_ctl #(.RW(RW), .BR_SQUASH(2)) dut (
        .clk      (clk),
        .clr      (clr),
        .a1       (a1),
        .a2       (a2),
        .use1     (use1),
        .use2     (use2),
        .st2      (st2),
        .wr2      (wr2),
        .ld2      (ld2),
        .dst2     (dst2),
        .cond2    (cond2),
        .hlt2     (hlt2),
        .mem_wait (mem_wait),
        .pause3   (pause3),
        .nop3     (nop3),
        .stall2   (stall2),
        .flush    (flush),
        .c5a      (c5a),
        .c6a      (c6a),
        .c7       (c7),
        .halted   (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic u1, input logic [RW-1:0] x1,
                         input logic u2, input logic [RW-1:0] x2,
                         input logic st, input logic wr, input logic ld,
                         input logic [RW-1:0] d);
        use1 = u1; a1 = x1; use2 = u2; a2 = x2; st2 = st;
        wr2 = wr; ld2 = ld; dst2 = d;
        cond2 = 1'b0; hlt2 = 1'b0; mem_wait = 1'b0;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic do_reset();
        idle();
        clr = 1'b0;
        #2;
        clr = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        clr = 1'b0;
        mem_wait = 1'b1; use1 = 1'b1; cond2 = 1'b1; hlt2 = 1'b1;
        tick();
        tick();
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL rst_outs got %b exp %b", outs, E_IDLE);
        end
        clr = 1'b1;
        idle();
        mem_wait = 1'b1;
        #1;
        checks++;
        if (outs !== E_PAUSE) begin
            errors++; $display("FAIL rst_pause_live got %b exp %b", outs, E_PAUSE);
        end
        tick();
        idle();
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL rst_idle got %b exp %b", outs, E_IDLE);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        nstall = FWD ? 2 : 3;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL lu_issue got %b exp %b", outs, E_IDLE);
        end
        tick();
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4);
        for (int i = 0; i < nstall; i++) begin
            #1;
            checks++;
            if (outs !== E_HAZ) begin
                errors++; $display("FAIL lu_stall[%0d] got %b exp %b", i, outs, E_HAZ);
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== (FWD ? E_C5A : E_IDLE)) begin
            errors++; $display("FAIL lu_fwd got %b exp %b", outs, (FWD ? E_C5A : E_IDLE));
        end
        tick();
    endtask

    task automatic test_forward_store();
        do_reset();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7);
        tick(); idle(); tick(); idle(); tick();
        // store of r7 whose address operand is also r7
        drive(1'b1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        checks++;
        if (outs !== (FWD ? 8'b0000_1010 : E_HAZ)) begin
            errors++; $display("FAIL fs_fwd got %b exp %b", outs, (FWD ? 8'b0000_1010 : E_HAZ));
        end
        tick();
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL fs_after got %b exp %b", outs, E_IDLE);
        end
        tick();
        // Y-operand read of r7, X-operand unrelated
        do_reset();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd7);
        tick(); idle(); tick(); idle(); tick();
        drive(1'b1, 5'd6, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 5'd1);
        #1;
        checks++;
        if (outs !== (FWD ? 8'b0000_0100 : E_HAZ)) begin
            errors++; $display("FAIL fs_c6a got %b exp %b", outs, (FWD ? 8'b0000_0100 : E_HAZ));
        end
        tick();
    endtask

    task automatic test_priority();
        do_reset();
        nstall = FWD ? 2 : 3;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);
        tick(); idle(); tick();
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd5);
        tick();
        // S3 holds the newer r5, S5 the older r5: the older copy must not forward
        drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        for (int i = 0; i < nstall; i++) begin
            #1;
            checks++;
            if (outs !== E_HAZ) begin
                errors++; $display("FAIL pr_stall[%0d] got %b exp %b", i, outs, E_HAZ);
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== (FWD ? E_C5A : E_IDLE)) begin
            errors++; $display("FAIL pr_fwd got %b exp %b", outs, (FWD ? E_C5A : E_IDLE));
        end
        tick();
    endtask

    task automatic test_pause_hold();
        do_reset();
        nstall = FWD ? 2 : 3;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'd3);
        tick();
        drive(1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        mem_wait = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== E_PAUSE) begin
                errors++; $display("FAIL ph_pause[%0d] got %b exp %b", i, outs, E_PAUSE);
            end
            tick();
        end
        mem_wait = 1'b0;
        for (int i = 0; i < nstall; i++) begin
            #1;
            checks++;
            if (outs !== E_HAZ) begin
                errors++; $display("FAIL ph_stall[%0d] got %b exp %b", i, outs, E_HAZ);
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== (FWD ? E_C5A : E_IDLE)) begin
            errors++; $display("FAIL ph_fwd got %b exp %b", outs, (FWD ? E_C5A : E_IDLE));
        end
        tick();
    endtask

    task automatic test_branch();
        do_reset();
        cond2 = 1'b1;
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL br_issue got %b exp %b", outs, E_IDLE);
        end
        tick();
        hlt2 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== E_FLUSH) begin
                errors++; $display("FAIL br_window[%0d] got %b exp %b", i, outs, E_FLUSH);
            end
            tick();
        end
        cond2 = 1'b0; hlt2 = 1'b0;
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL br_end got %b exp %b", outs, E_IDLE);
        end
        tick();
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL br_no_drain got %b exp %b", outs, E_IDLE);
        end
        tick();
    endtask

    task automatic test_pause_squash();
        do_reset();
        cond2 = 1'b1;
        tick();
        cond2 = 1'b0;
        mem_wait = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== E_PFLUSH) begin
                errors++; $display("FAIL ps_pause[%0d] got %b exp %b", i, outs, E_PFLUSH);
            end
            tick();
        end
        mem_wait = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== E_FLUSH) begin
                errors++; $display("FAIL ps_flush[%0d] got %b exp %b", i, outs, E_FLUSH);
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL ps_end got %b exp %b", outs, E_IDLE);
        end
        tick();
    endtask

    task automatic test_hazard_branch();
        do_reset();
        nstall = FWD ? 2 : 3;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd9);
        tick();
        drive(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        cond2 = 1'b1;
        for (int i = 0; i < nstall; i++) begin
            #1;
            checks++;
            if (outs !== E_HAZ) begin
                errors++; $display("FAIL hb_stall[%0d] got %b exp %b", i, outs, E_HAZ);
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== (FWD ? E_C5A : E_IDLE)) begin
            errors++; $display("FAIL hb_issue got %b exp %b", outs, (FWD ? E_C5A : E_IDLE));
        end
        tick();
        idle();
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== E_FLUSH) begin
                errors++; $display("FAIL hb_flush[%0d] got %b exp %b", i, outs, E_FLUSH);
            end
            tick();
        end
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL hb_end got %b exp %b", outs, E_IDLE);
        end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'(i));
            tick();
        end
        idle();
        hlt2 = 1'b1;
        #1;
        checks++;
        if ({stall2, halted} !== 2'b00) begin
            errors++; $display("FAIL ht_accept got %b exp %b", {stall2, halted}, 2'b00);
        end
        tick();
        hlt2 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (outs !== E_HAZ) begin
                errors++; $display("FAIL ht_drain[%0d] got %b exp %b", i, outs, E_HAZ);
            end
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (outs !== E_HALT) begin
                errors++; $display("FAIL ht_halted[%0d] got %b exp %b", i, outs, E_HALT);
            end
            tick();
        end
        #1;
        clr = 1'b0;
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL ht_clr got %b exp %b", outs, E_IDLE);
        end
        clr = 1'b1;
        tick();
        drive(1'b1, 5'd3, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL ht_after_reset got %b exp %b", outs, E_IDLE);
        end
        tick();
    endtask

    task automatic test_reset_abandon();
        do_reset();
        cond2 = 1'b1;
        tick();
        cond2 = 1'b0;
        #1;
        checks++;
        if (outs !== E_FLUSH) begin
            errors++; $display("FAIL ra_squash got %b exp %b", outs, E_FLUSH);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL ra_clr got %b exp %b", outs, E_IDLE);
        end
        #1;
        clr = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== E_IDLE) begin
            errors++; $display("FAIL ra_run got %b exp %b", outs, E_IDLE);
        end
        tick();
    endtask

    initial begin
        clr = 1'b0;
        idle();
        test_reset();
        test_load_use();
        test_forward_store();
        test_priority();
        test_pause_hold();
        test_branch();
        test_pause_squash();
        test_hazard_branch();
        test_halt();
        test_reset_abandon();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctl.md
HAZARD_CTL -- requirements
Module: hazard_ctl

Interface
REQ-001 Parameter: RW, 5, register-address width.
REQ-002 Parameter: BR_SQUASH, 2, wrong-path cycles squashed after a taken branch (1..3).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed below.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 clr  in  1  asynchronous active-low reset.
REQ-006 a1  in  RW  stage-2 source 1 (X operand).
REQ-007 a2  in  RW  stage-2 source 2 (Y operand / store data).
REQ-008 use1, use2  in  1 each  stage-2 instruction reads a1 / reads a2 into Y3.
REQ-009 st2  in  1  stage-2 instruction is st/stx (a2 is store data).
REQ-010 wr2, ld2  in  1 each  stage-2 instruction writes a register / is ld/ldi/ldx.
REQ-011 dst2  in  RW  stage-2 destination register (IR2[26:22]).
REQ-012 cond2, hlt2  in  1 each  stage-2 taken branch (COND2) / hlt decoded.
REQ-013 mem_wait  in  1  memory stage not ready.
REQ-014 pause3, nop3, stall2, flush  out  1 each  hold stage-3 regs / load NOP into IR3 / hold IR2,PC2 / kill fetch.
REQ-015 c5a, c6a, c7  out  1 each  X3, Y3, MD3 take Z5.
REQ-016 halted  out  1  processor stopped.

Function
REQ-017 Tracker SHALL hold entries S3,S4,S5, each {valid, wr, ld, dst}, describing instructions in stages 3-5.
REQ-018 pause3 = mem_wait; while pause3=1, tracker, counter and state SHALL hold, stall2=1, nop3=0.
REQ-019 Otherwise each clk SHALL shift S5<=S4, S4<=S3, S3<=(nop3 ? invalid : {1,wr2,ld2,dst2}).
REQ-020 Hazard: use1 with a1, or (use2|st2) with a2, matching a valid wr entry in S3 or S4; SHALL give stall2=1, nop3=1 in the same cycle (combinational).
REQ-021 Forward: c5a=use1 & S5 match on a1; c6a=use2 & S5 match on a2; c7=st2 & S5 match on a2; all SHALL be forced 0 while a hazard or squash is active.
REQ-022 An S3/S4 match SHALL take priority over an S5 match; the older copy is never forwarded.
REQ-023 Taken branch: cond2=1 while not squashing SHALL load the squash counter with BR_SQUASH.
REQ-024 While the counter is nonzero: flush=1, nop3=1, cond2 and hlt2 ignored; it decrements once per unpaused cycle.
REQ-025 FSM states SHALL be RUN, DRAIN and HALT.
REQ-026 RUN->DRAIN on hlt2 when not squashing and no hazard.
REQ-027 DRAIN: stall2=1, nop3=1; ->HALT when S3,S4,S5 are all invalid.
REQ-028 HALT: halted=1, stall2=1, nop3=1; exit only by reset.
REQ-029 Simultaneous hazard and cond2: the hazard wins; the branch is re-evaluated when it issues.
REQ-030 Counter saturates at 0 and never wraps.

Reset
REQ-031 clr=0 SHALL clear all tracker valids, zero the counter, enter RUN and drive every output to 0 immediately, independent of clk.
REQ-032 Reset mid-DRAIN or mid-squash SHALL abandon it; the first edge after release behaves as RUN with an empty tracker.

Configuration
REQ-033 Macro VESPA_FWD_EN: when defined, forwarding operates per REQ-021.
REQ-034 Without VESPA_FWD_EN: c5a, c6a and c7 are tied 0, and an S5 match is also a hazard per REQ-020 (S3/S4/S5 all stall).

Verification
REQ-035 Load-use: ld r3 issues, next instruction has use1, a1=3 -> stall2=nop3=1 for 2 cycles, then c5a=1 for 1 cycle (FWD_EN).
REQ-036 Forward: S5 has wr, dst=7; stage-2 st2=1, a2=7 -> c7=1, stall2=0; without VESPA_FWD_EN -> stall2=1 for 1 cycle.
REQ-037 Branch: cond2=1, BR_SQUASH=2 -> flush=nop3=1 for exactly 2 unpaused cycles; hlt2 during the window is ignored.
REQ-038 mem_wait held 3 cycles during a squash -> counter frozen, pause3=1 for 3 cycles, flush lasts 2+3 cycles.
REQ-039 hlt2 with 3 valid entries -> DRAIN for 3 cycles, then halted=1; clr=0 -> halted=0 asynchronously.
REQ-040 Hazard and cond2 in the same cycle -> no squash starts that cycle; the squash starts after the branch issues.
